// File: rtl/imem_pkg.sv
// +----------------------------------------------------------------------------+
// | imem_pkg : shared FSM encoding and default sizing for the prefetch unit    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

package imem_pkg;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_FETCH = 1'b1
   } fetch_state_e;

   localparam int C_DEF_DATA_WIDTH = 16;
   localparam int C_DEF_ADDR_WIDTH = 16;
   localparam int C_DEF_MEM_AW     = 10;
   localparam int C_DEF_QDEPTH     = 4;

   // Byte step between consecutive instruction words.
   localparam int C_PC_STEP        = 2;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// +----------------------------------------------------------------------------+
// | sync_fifo : single-clock FIFO with flush; head is read from flops only     |
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush_i,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         push_data_i,
   input  logic                     pop_i,
   output logic                     valid_o,
   output logic [WIDTH-1:0]         head_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int              PW     = $clog2(DEPTH);
   localparam logic [PW:0]     C_FULL = (PW+1)'(DEPTH);

   logic [WIDTH-1:0] store_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q;
   logic [PW-1:0]    rd_ptr_q;
   logic [PW:0]      count_q;

   logic             w_pop;
   logic             w_push;

   // Flush discards everything, including a push or pop arriving with it.
   assign w_pop  = pop_i  && !flush_i && (count_q != '0);
   assign w_push = push_i && !flush_i && ((count_q != C_FULL) || w_pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            store_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (w_push) begin
            store_q[wr_ptr_q] <= push_data_i;
            wr_ptr_q          <= wr_ptr_q + 1'b1;
         end
         if (w_pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         count_q <= count_q + {{PW{1'b0}}, w_push} - {{PW{1'b0}}, w_pop};
      end
   end

   assign valid_o = (count_q != '0);
   assign head_o  = store_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/imem_prefetch.sv
// +----------------------------------------------------------------------------+
// | imem_prefetch : program memory plus prefetch queue feeding a consumer      |
// | Revision      : 1.0                                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module imem_prefetch
   import imem_pkg::*;
#(
   parameter int DATA_WIDTH = C_DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = C_DEF_ADDR_WIDTH,
   parameter int MEM_AW     = C_DEF_MEM_AW,
   parameter int QDEPTH     = C_DEF_QDEPTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] start_pc,
   input  logic                  redirect,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   input  logic                  halt,
   input  logic                  prog_we,
   input  logic [MEM_AW-1:0]     prog_addr,
   input  logic [DATA_WIDTH-1:0] prog_data,
   input  logic                  out_ready,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_instr,
   output logic [ADDR_WIDTH-1:0] out_pc
);

   localparam int               CW       = $clog2(QDEPTH) + 1;
   localparam logic [CW-1:0]    C_QDEPTH = CW'(QDEPTH);
   localparam int               FW       = DATA_WIDTH + ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem_q [2**MEM_AW];

   fetch_state_e          state_q;
   logic [ADDR_WIDTH-1:0] fetch_pc_q;
   logic [ADDR_WIDTH-1:0] fetch_pc_d;
   logic [ADDR_WIDTH-1:0] rd_pc_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic                  inflight_q;

   logic                  w_jump;
   logic [ADDR_WIDTH-1:0] w_target;
   logic [ADDR_WIDTH-1:0] w_rd_pc;
   logic [MEM_AW-1:0]     w_rd_idx;
   logic [CW-1:0]         w_count;
   logic [CW-1:0]         w_occ;
   logic                  w_issue;
   logic                  w_push;
   logic                  w_pop;
   logic [FW-1:0]         w_head;

   // Start in either state behaves as a redirect to start_pc; redirect wins.
   assign w_jump   = redirect || start;
   assign w_target = redirect ? redirect_pc : start_pc;

   // A jump reads its target in the same cycle, giving a two-cycle start latency.
   assign w_rd_pc  = w_jump ? w_target : fetch_pc_q;
   assign w_rd_idx = w_rd_pc[MEM_AW:1];
   assign w_occ    = w_count + {{(CW-1){1'b0}}, inflight_q};
   assign w_issue  = !halt && (w_jump || ((state_q == ST_FETCH) && (w_occ < C_QDEPTH)));

   assign w_push   = inflight_q && !w_jump;
   assign w_pop    = out_valid && out_ready && !w_jump;

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      if (w_issue) begin
         fetch_pc_d = w_rd_pc + ADDR_WIDTH'(C_PC_STEP);
      end else if (w_jump) begin
         fetch_pc_d = w_target;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         fetch_pc_q <= '0;
         rd_pc_q    <= '0;
         inflight_q <= 1'b0;
      end else begin
         if (w_jump) begin
            state_q <= ST_FETCH;
         end
         fetch_pc_q <= fetch_pc_d;
         inflight_q <= w_issue;
         if (w_issue) begin
            rd_pc_q <= w_rd_pc;
         end
      end
   end

   // Program load; a same-cycle read of the same word sees the old contents.
   always_ff @(posedge clk) begin
      if (prog_we && !rst) begin
         mem_q[prog_addr] <= prog_data;
      end
   end

   always_ff @(posedge clk) begin
      if (w_issue && !rst) begin
         rdata_q <= mem_q[w_rd_idx];
      end
   end

   sync_fifo #(
      .WIDTH (FW),
      .DEPTH (QDEPTH)
   ) u_queue (
      .clk         (clk),
      .rst         (rst),
      .flush_i     (w_jump),
      .push_i      (w_push),
      .push_data_i ({rd_pc_q, rdata_q}),
      .pop_i       (w_pop),
      .valid_o     (out_valid),
      .head_o      (w_head),
      .count_o     (w_count)
   );

   assign out_pc    = w_head[FW-1:DATA_WIDTH];
   assign out_instr = w_head[DATA_WIDTH-1:0];

endmodule

`default_nettype wire

// File: doc/imem_prefetch.md
IMEM_PREFETCH -- requirements
Module: imem_prefetch

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, instruction word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, byte-address (PC) width.
REQ-003 SHALL have parameter MEM_AW, default 10, log2 of memory depth in words.
REQ-004 SHALL have parameter QDEPTH, default 4, prefetch queue entries (power of two, >=2).
REQ-005 SHALL have port clk  input  1  clock, all logic rising-edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port start  input  1  one-cycle pulse, begins fetching at start_pc.
REQ-008 SHALL have port start_pc  input  ADDR_WIDTH  initial fetch byte address.
REQ-009 SHALL have port redirect  input  1  branch/jump, flush and refetch.
REQ-010 SHALL have port redirect_pc  input  ADDR_WIDTH  redirect target byte address.
REQ-011 SHALL have port halt  input  1  stop issuing new memory reads.
REQ-012 SHALL have port prog_we  input  1  program-load write enable.
REQ-013 SHALL have port prog_addr  input  MEM_AW  program-load word index.
REQ-014 SHALL have port prog_data  input  DATA_WIDTH  program-load data.
REQ-015 SHALL have port out_ready  input  1  consumer accepts head entry.
REQ-016 SHALL have port out_valid  output  1  head entry valid.
REQ-017 SHALL have port out_instr  output  DATA_WIDTH  head instruction.
REQ-018 SHALL have port out_pc  output  ADDR_WIDTH  byte address of head instruction.

Function
REQ-019 SHALL hold 2^MEM_AW words; word index = fetch_pc[MEM_AW:1]; pc bit 0 and bits above MEM_AW ignored (aliasing).
REQ-020 SHALL implement FSM IDLE -> FETCH on start or redirect; FETCH -> IDLE never except by rst; halt only gates issue.
REQ-021 SHALL issue one memory read per cycle in FETCH when !halt and (count + inflight) < QDEPTH; read data arrives one cycle later and is pushed with its pc.
REQ-022 SHALL advance fetch_pc by 2 per issued read, wrapping modulo 2^ADDR_WIDTH.
REQ-023 SHALL pop on out_valid && out_ready; push and pop in the same cycle keep count unchanged.
REQ-024 SHALL present out_valid = (count != 0), out_instr/out_pc from queue head, registered, no combinational path from out_ready.
REQ-025 SHALL on redirect (any state): empty queue, discard the in-flight read, set fetch_pc = redirect_pc, enter FETCH; first read issues the same cycle the redirect is registered +1; out_valid is 0 the cycle after redirect.
REQ-026 SHALL give redirect priority over a coincident pop, push, or start; coincident pop is void.
REQ-027 SHALL treat start in FETCH as a redirect to start_pc.
REQ-028 SHALL write prog_data on prog_we; read and write to the same word in one cycle returns old data.
REQ-029 SHALL never overflow the queue nor drop a non-flushed instruction; first instruction after start appears on out_valid 2 cycles after start.

Reset
REQ-030 SHALL on rst: FSM IDLE, count 0, inflight 0, fetch_pc 0, out_valid 0, out_instr 0, out_pc 0; memory contents not reset.
REQ-031 SHALL let rst override start, redirect and prog_we in the same cycle (prog_we ignored).

Structure
REQ-032 SHALL place FSM state encoding and default parameter constants in shared package imem_pkg.
REQ-033 SHALL instantiate one sub-module, sync_fifo (DATA_WIDTH+ADDR_WIDTH wide, QDEPTH deep, with flush input); memory array and FSM stay in imem_prefetch.

Verification
REQ-034 SHALL cover: preload words 0..7 = 0x1000+i, start_pc=0, out_ready=1 -> out_instr 0x1000,0x1001,... out_pc 0,2,4,... one per cycle after 2-cycle latency.
REQ-035 SHALL cover: out_ready=0 for 10 cycles after start -> count saturates at 4, exactly 4 instructions later emerge in order, none lost or duplicated.
REQ-036 SHALL cover: redirect to 0x0010 while queue full and pop asserted -> next accepted instruction has out_pc 0x0010, stale entries never appear.
REQ-037 SHALL cover: start_pc=0xFFFE, ADDR_WIDTH=16 -> out_pc 0xFFFE then 0x0000, word index wraps to 1023 then 0.
REQ-038 SHALL cover: rst asserted mid-FETCH with queue half full -> next cycle out_valid 0, out_pc 0, no fetch until new start.
REQ-039 SHALL cover: halt=1 during FETCH -> in-flight read still pushed, no further issue, resumes at correct pc when halt=0.
